// File: rtl/cond_flags_unit.sv
// Condition-flag register (NZVC) and branch-resolution unit.
// Forwards same-cycle EX flags into evaluation; registered decision plus saturating taken count.
module cond_flags_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic             br_reg_zero,
  output logic [3:0]       flags_q,
  output logic             decision_valid,
  output logic             take_branch,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       w_upd;
  logic [3:0] w_alu_flags;
  logic [3:0] w_eff;
  logic       w_n;
  logic       w_z;
  logic       w_v;
  logic       w_c;
  logic       w_cond;
  logic       w_taken;
  logic       w_take_next;

  // Flag-setter in EX bypasses the register so a same-cycle branch sees it.
  always_comb begin
    w_alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
    w_upd       = ex_valid & ex_set_flags & ~flush;
    w_eff       = w_upd ? w_alu_flags : flags_q;
  end

  assign w_n = w_eff[3];
  assign w_z = w_eff[2];
  assign w_v = w_eff[1];
  assign w_c = w_eff[0];

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      4'b0000: w_cond = w_z;
      4'b0001: w_cond = ~w_z;
      4'b0010: w_cond = w_c;
      4'b0011: w_cond = ~w_c;
      4'b0100: w_cond = w_n;
      4'b0101: w_cond = ~w_n;
      4'b0110: w_cond = w_v;
      4'b0111: w_cond = ~w_v;
      4'b1000: w_cond = w_c & ~w_z;
      4'b1001: w_cond = ~w_c | w_z;
      4'b1010: w_cond = (w_n == w_v);
      4'b1011: w_cond = (w_n != w_v);
      4'b1100: w_cond = ~w_z & (w_n == w_v);
      4'b1101: w_cond = w_z | (w_n != w_v);
      default: w_cond = 1'b1;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_type)
      2'b00:   w_taken = 1'b1;
      2'b01:   w_taken = w_cond;
      2'b10:   w_taken = br_reg_zero;
      default: w_taken = ~br_reg_zero;
    endcase
  end

  assign w_take_next = br_valid & ~flush & w_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      decision_valid <= 1'b0;
      take_branch    <= 1'b0;
      taken_count    <= '0;
    end else begin
      if (w_upd) flags_q <= w_alu_flags;
      decision_valid <= br_valid & ~flush;
      take_branch    <= w_take_next;
      // Saturate rather than wrap.
      if (w_take_next && (taken_count != CNT_MAX))
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed self-checking bench for cond_flags_unit (counter narrowed to 4 bits).
module tb_cond_flags_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic             ex_valid, ex_set_flags, flush;
  logic             br_valid;
  logic [1:0]       br_type;
  logic [3:0]       br_cond;
  logic             br_reg_zero;
  logic [3:0]       flags_q;
  logic             decision_valid;
  logic             take_branch;
  logic [CNT_W-1:0] taken_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  cond_flags_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .flush(flush),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond),
    .br_reg_zero(br_reg_zero),
    .flags_q(flags_q), .decision_valid(decision_valid),
    .take_branch(take_branch), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic sf, input logic fl, input logic [3:0] nzvc,
                       input logic bv, input logic [1:0] bt, input logic [3:0] bc, input logic rz);
    ex_valid = ev; ex_set_flags = sf; flush = fl;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = nzvc;
    br_valid = bv; br_type = bt; br_cond = bc; br_reg_zero = rz;
  endtask

  // Advance one edge, then check decision, direction, flags and the counter model.
  task automatic step_chk(input string tag, input logic exp_dv, input logic exp_tb,
                          input logic [3:0] exp_flags);
    tick();
    if (exp_tb && exp_cnt < 15) exp_cnt++;
    check_eq({tag, ".dv"},    16'(decision_valid), 16'(exp_dv));
    check_eq({tag, ".take"},  16'(take_branch),    16'(exp_tb));
    check_eq({tag, ".flags"}, 16'(flags_q),        16'(exp_flags));
    check_eq({tag, ".cnt"},   16'(taken_count),    16'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0);
    tick(); tick();
    check_eq("rst.flags", 16'(flags_q), 16'h0);
    check_eq("rst.cnt",   16'(taken_count), 16'h0);
    reset = 1'b0;

    // Build up nonzero state, then reset mid-cycle with a query pending.
    drive(1, 1, 0, 4'b1111, 1, 2'b00, 4'b0000, 0);
    step_chk("pre", 1, 1, 4'b1111);
    drive(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0000, 0);
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    check_eq("midrst.flags", 16'(flags_q),        16'h0);
    check_eq("midrst.dv",    16'(decision_valid), 16'h0);
    check_eq("midrst.take",  16'(take_branch),    16'h0);
    check_eq("midrst.cnt",   16'(taken_count),    16'h0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0);
    step_chk("postrst", 0, 0, 4'b0000);

    drive(1, 1, 0, 4'b1001, 0, 2'b00, 4'b0000, 0);
    step_chk("upd1001", 0, 0, 4'b1001);

    // Forwarding: clear flags, then SUBS Z=1 with B.EQ in the same cycle.
    drive(1, 1, 0, 4'b0000, 0, 2'b00, 4'b0000, 0);
    step_chk("clr", 0, 0, 4'b0000);
    drive(1, 1, 0, 4'b0100, 1, 2'b01, 4'b0000, 0);
    step_chk("fwd.eq", 1, 1, 4'b0100);

    // Signed conditions with N=1,V=0 (first forwarded, rest from register).
    drive(1, 1, 0, 4'b1000, 1, 2'b01, 4'b1010, 0);
    step_chk("ge.nv10", 1, 0, 4'b1000);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1011, 0);
    step_chk("lt.nv10", 1, 1, 4'b1000);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1100, 0);
    step_chk("gt.nv10", 1, 0, 4'b1000);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1101, 0);
    step_chk("le.nv10", 1, 1, 4'b1000);
    drive(1, 1, 0, 4'b1010, 1, 2'b01, 4'b1010, 0);
    step_chk("ge.nv11", 1, 1, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1011, 0);
    step_chk("lt.nv11", 1, 0, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b0000, 0);
    step_chk("eq.z0", 1, 0, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1000, 0);
    step_chk("hi.c0", 1, 0, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b0110, 0);
    step_chk("vs", 1, 1, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b01, 4'b1111, 0);
    step_chk("nv.always", 1, 1, 4'b1010);

    // Compare-and-branch and unconditional; flags must not move.
    drive(0, 0, 0, 4'b0000, 1, 2'b10, 4'b0000, 1);
    step_chk("cbz.rz1", 1, 1, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b11, 4'b1110, 1);
    step_chk("cbnz.rz1", 1, 0, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b11, 4'b0000, 0);
    step_chk("cbnz.rz0", 1, 1, 4'b1010);
    drive(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0000, 0);
    step_chk("b.any", 1, 1, 4'b1010);

    // Flush squashes both flag update and query.
    drive(1, 1, 1, 4'b0101, 1, 2'b01, 4'b1110, 0);
    step_chk("flush", 0, 0, 4'b1010);
    // Non-flag-setter and bubble leave flags alone; EQ uses held Z=0.
    drive(1, 0, 0, 4'b1111, 1, 2'b01, 4'b0000, 0);
    step_chk("nosf", 1, 0, 4'b1010);
    drive(0, 1, 0, 4'b1111, 1, 2'b01, 4'b0000, 0);
    step_chk("bubble", 1, 0, 4'b1010);
    drive(0, 0, 0, 4'b0000, 0, 2'b00, 4'b0000, 0);
    step_chk("idle", 0, 0, 4'b1010);

    // Saturation: 20 unconditional branches on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 4'b0000, 1, 2'b00, 4'b0000, 0);
      step_chk($sformatf("sat%0d", i), 1, 1, 4'b1010);
    end
    check_eq("sat.final", 16'(taken_count), 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Condition-flag register and branch-resolution unit for the pipelined CPU. It captures the ALU status outputs (negative, zero, overflow, carry_out) from flag-setting instructions in EX and holds them as the architectural NZVC state. It evaluates B.cond, CBZ, CBNZ and B queries against these flags, forwarding same-cycle EX results. It returns a registered taken/not-taken decision one cycle later and keeps a saturating count of taken branches.

## Interface
Parameters:
- CNT_W, 16, width of the taken-branch counter

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- alu_negative  in  1  ALU negative flag, EX stage
- alu_zero  in  1  ALU zero flag, EX stage
- alu_overflow  in  1  ALU overflow flag, EX stage
- alu_carry_out  in  1  ALU carry-out flag, EX stage
- ex_valid  in  1  EX stage holds a real instruction (not a bubble)
- ex_set_flags  in  1  EX instruction is flag-setting (ADDS/SUBS/ANDS class)
- flush  in  1  pipeline squash for this cycle
- br_valid  in  1  branch query present this cycle
- br_type  in  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ
- br_cond  in  4  condition code for B.cond
- br_reg_zero  in  1  tested register is zero (ALU pass-B, cntrl 000, zero output)
- flags_q  out  4  architectural flags {N,Z,V,C}
- decision_valid  out  1  take_branch is meaningful this cycle
- take_branch  out  1  resolved branch direction
- taken_count  out  CNT_W  saturating count of taken branches

## Operation
- upd = ex_valid & ex_set_flags & ~flush.
- On each rising clk edge where upd = 1: flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry_out}. Otherwise flags_q holds its value.
- Effective flags for evaluation: eff = upd ? {alu flags} : flags_q. This combinational forward means a branch issued in the same cycle as its flag-setter sees the new flags, with no stall.
- Condition codes, evaluated on eff:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 ~Z&(N==V); 1101 Z|(N!=V)
  - 1110 and 1111 always true
- Direction by br_type:
  - 00: taken = 1
  - 01: taken = cond(br_cond)
  - 10: taken = br_reg_zero
  - 11: taken = ~br_reg_zero
- br_cond is ignored unless br_type = 01. br_reg_zero is ignored unless br_type is 10 or 11.
- Registered outputs update at each edge:
  - decision_valid <= br_valid & ~flush
  - take_branch <= br_valid & ~flush & taken
- taken_count increments by 1 on each edge where the new take_branch is 1. It saturates at 2^CNT_W-1 and never wraps.
- flush squashes both the EX flag update and the branch query in the same cycle.

## Timing
- Reset (async, immediate, independent of clk): flags_q = 4'b0000, decision_valid = 0, take_branch = 0, taken_count = 0.
- Reset asserted mid-stream discards any pending query. The first decision after reset deassertion reflects only post-reset inputs.
- Flag update latency: 1 cycle to flags_q. Forwarded path to evaluation: 0 cycles.
- Branch decision latency: query in cycle t appears on decision_valid/take_branch in cycle t+1, held for exactly one cycle unless a new query arrives.
- Back-to-back queries are accepted every cycle. No backpressure.
- When decision_valid = 0, take_branch = 0.
- Two consecutive flag-setters: each overwrites flags_q. The later one is seen by queries in its own cycle.
- A non-flag-setting EX instruction (ex_set_flags = 0) or a bubble (ex_valid = 0) leaves flags untouched.

## Test plan
- Reset/update: assert reset mid-cycle. Expect all outputs 0 immediately. Release, then drive upd with N=1,Z=0,V=0,C=1. Expect flags_q = 4'b1001 next cycle.
- Forwarding: flags_q = 0000. In the same cycle, SUBS produces Z=1 and B.cond EQ (0000) is queried. Expect decision_valid = 1, take_branch = 1 next cycle, and flags_q = 0100.
- Signed conditions: eff N=1,V=0. GE (1010) gives take 0, LT (1011) gives 1, GT (1100) gives 0, LE (1101) gives 1. Repeat with N=1,V=1: GE 1, LT 0.
- Compare-branches: CBZ with br_reg_zero=1 gives take 1. CBNZ with br_reg_zero=1 gives 0. br_type 00 with any inputs gives 1. flags_q is unchanged throughout.
- Flush: upd inputs and a B.cond query with flush = 1. Expect flags_q unchanged, decision_valid = 0, take_branch = 0, taken_count unchanged.
- Counter saturation: CNT_W = 4. Issue 20 consecutive unconditional branches. Expect taken_count to reach 15 and stay at 15.
